uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing the single UART transmit FIFO write port (`TX_data` / `wr_uart_en` / `Full`) among `NUM_REQ` byte-stream requesters. A grant is held for a whole message: until the requester marks its last byte or a burst limit is reached. This keeps one message from interleaving with another on the TX line. It sits between on-chip producers (AXI bridge, debug console, status reporter) and the `UART` block's TX side.

---
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART TX FIFO write port among NUM_REQ byte streams,
// holding each grant for a whole message. Define UART_ARB_TIMEOUT_EN to release idle grantees.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 TX_data,
  output logic                       wr_uart_en,
  input  logic                       Full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int GW1 = GW + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 256 || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [7:0]    burst_cnt;
  logic [GW-1:0] pick;
  logic          any_req;
  logic          accept;
  logic          last_hit;
  logic          timeout;
  logic          release_grant;
  logic [GW-1:0] ptr_after;

  // First asserted requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    logic [GW1-1:0] idx;
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + GW1'(i);
      if (idx >= GW1'(NUM_REQ)) idx = idx - GW1'(NUM_REQ);
      if (!any_req && req_valid[idx[GW-1:0]]) begin
        any_req = 1'b1;
        pick    = idx[GW-1:0];
      end
    end
  end

  assign accept    = (state == XFER) && req_valid[grant_id] && !Full;
  assign last_hit  = req_last[grant_id] || (burst_cnt == 8'(MAX_BURST - 1));
  assign ptr_after = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IW-1:0] idle_cnt;

  assign timeout = (state == XFER) && !req_valid[grant_id]
                   && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idle_cnt <= '0;
    end else if (state == IDLE || req_valid[grant_id]) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign release_grant = (accept && last_hit) || timeout;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = XFER;
      XFER:    if (release_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    req_ready  = '0;
    wr_uart_en = 1'b0;
    TX_data    = '0;
    if (state == XFER) begin
      busy                = 1'b1;
      req_ready[grant_id] = !Full;
      wr_uart_en          = accept;
      TX_data             = req_data[8*grant_id +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        grant_id  <= pick;
        burst_cnt <= '0;
      end
    end else begin
      if (accept) burst_cnt <= burst_cnt + 1'b1;
      if (release_grant) rr_ptr <= ptr_after;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level arbiter model predicts every cycle's
// outputs into a scoreboard queue that an independent negedge monitor drains and compares.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 8;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     TX_data;
  logic           wr_uart_en;
  logic           Full;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 Clk = ~Clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .TX_data(TX_data),
    .wr_uart_en(wr_uart_en), .Full(Full), .grant_id(grant_id), .busy(busy)
  );

  typedef struct packed {
    logic       busy;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       wr;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("wr_uart_en", 32'(wr_uart_en), 32'(e.wr));
      check("TX_data",    32'(TX_data),    32'(e.data));
      check("busy",       32'(busy),       32'(e.busy));
      check("grant_id",   32'(grant_id),   32'(e.gid));
      check("req_ready",  32'(req_ready),  32'(e.rdy));
    end
  end

  // Requester side: pending bytes per requester as {last, data}.
  bit [8:0] rq[N][$];
  bit       vld[N];
  bit [7:0] cur_data[N];
  int       full_pct = 0;
  int       gap_pct  = 0;

  // Arbiter model: who owns the port, how many bytes this grant moved, where the search starts.
  bit m_own  = 0;
  int m_gid  = 0;
  int m_sent = 0;
  int m_ptr  = 0;
  int m_idle = 0;

  task automatic step(input bit rst);
    exp_t e;
    @(posedge Clk); #1;
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && rq[i].size() > 0 && $urandom_range(99) >= gap_pct) vld[i] = 1;
      cur_data[i] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'($urandom);
      req_valid[i] = vld[i];
      req_last[i]  = vld[i] ? rq[i][0][8] : 1'($urandom);
      req_data[i*8 +: 8] = cur_data[i];
    end
    Reset = rst;
    Full  = rst ? 1'b1 : ($urandom_range(99) < full_pct);

    e.busy = m_own;
    e.gid  = 2'(m_gid);
    e.rdy  = (m_own && !Full) ? 4'(1 << m_gid) : 4'b0;
    e.wr   = m_own && vld[m_gid] && !Full;
    e.data = m_own ? cur_data[m_gid] : 8'h00;
    sbq.push_back(e);

    if (rst) begin
      m_own = 0; m_gid = 0; m_sent = 0; m_ptr = 0; m_idle = 0;
    end else if (!m_own) begin
      for (int k = 0; k < N; k++) begin
        if (!m_own && vld[(m_ptr + k) % N]) begin
          m_own = 1; m_gid = (m_ptr + k) % N; m_sent = 0; m_idle = 0;
        end
      end
    end else if (e.wr) begin
      bit lst;
      lst = rq[m_gid][0][8];
      void'(rq[m_gid].pop_front());
      vld[m_gid] = 0;
      m_sent++;
      if (lst || m_sent == MB) begin
        m_own = 0;
        m_ptr = (m_gid + 1) % N;
      end
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      if (vld[m_gid]) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin
          m_own = 0;
          m_ptr = (m_gid + 1) % N;
        end
      end
`endif
    end
  endtask

  task automatic add_msg(input int r, input int len);
    for (int b = 0; b < len; b++)
      rq[r].push_back({(b == len - 1), 8'($urandom)});
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 0;
    return !m_own;
  endfunction

  initial begin
    Reset = 1'b1; Full = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++) vld[i] = 0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset busy",       32'(busy),       32'd0);
    check("reset wr_uart_en", 32'(wr_uart_en), 32'd0);
    check("reset req_ready",  32'(req_ready),  32'd0);
    check("reset TX_data",    32'(TX_data),    32'd0);
    check("reset grant_id",   32'(grant_id),   32'd0);

    // Single requester 2 sends "ABC".
    rq[2].push_back(9'h041); rq[2].push_back(9'h042); rq[2].push_back(9'h143);
    repeat (8) step(0);
    check("rr_ptr after single msg", 32'(m_ptr), 32'd3);

    // Requesters 0,1,3 each keep single-byte messages pending.
    for (int m = 0; m < 4; m++) begin add_msg(0, 1); add_msg(1, 1); add_msg(3, 1); end
    repeat (30) step(0);

    // Long stream on 0 with 1 pending exercises the burst limit.
    add_msg(0, 40); add_msg(1, 3);
    repeat (70) step(0);

    // Backpressure, gaps and occasional resets on all requesters.
    full_pct = 25; gap_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (rq[i].size() < 4 && $urandom_range(9) == 0) add_msg(i, $urandom_range(1, 24));
      step($urandom_range(299) == 0);
    end

    full_pct = 0; gap_pct = 0;
    begin
      int budget;
      budget = 0;
      while (!all_done() && budget < 5000) begin step(0); budget++; end
      check("drain within budget", 32'(all_done()), 32'd1);
    end
    repeat (3) step(0);
    @(negedge Clk); #1;
    check("scoreboard empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
